// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin register-file write arbiter
//
// Purpose:
//   Arbitrates write requests from two requesters onto a single register-file
//   write port. A two-state FSM (IDLE/WRITE) samples requests in IDLE, picks a
//   winner round-robin, and presents one registered write strobe plus a
//   one-cycle ack to the winner. At most one write every two cycles.
//
// Configuration:
//   REGARB_FORWARD_EN - when defined, the read-data outputs bypass the
//                       register file with the in-flight write data on an
//                       index match. When undefined, reads pass straight through.
//
// Ports:
//   clock, reset_n            single rising-edge clock, async active-low reset
//   req0/1, addr0/1, data0/1  per-requester write request, index and data
//   ack0/1                    one-cycle write-accepted pulse per requester
//   write_en/reg/data         registered register-file write port
//   wr_count                  8-bit wrapping count of completed writes
//   rd_addr1/2, rf_data1/2    register-file read indices and read data
//   fwd_data1/2               read data delivered to the datapath

module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,

  output logic              write_en,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic [7:0]        wr_count,

  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;        // preferred requester on a tie
  logic                write_en_q, write_en_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic [7:0]          wr_count_q, wr_count_d;

  logic                any_req;
  logic                gnt;                 // 0 = requester 0, 1 = requester 1

  // Grant selection: the pointer only matters when both request; a lone
  // requester always wins.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      gnt = ptr_q;
    end else begin
      gnt = req1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    write_en_d   = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    // The register file takes the write on the edge that ends the strobe,
    // so the completion count advances on that same edge.
    wr_count_d   = write_en_q ? (wr_count_q + 8'd1) : wr_count_q;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d      = ST_WRITE;
          write_en_d   = 1'b1;
          ack0_d       = ~gnt;
          ack1_d       = gnt;
          ptr_d        = ~gnt;
          write_reg_d  = gnt ? addr1 : addr0;
          write_data_d = gnt ? data1 : data0;
        end
      end
      ST_WRITE: begin
        // Requests seen here are ignored; the requester still holds them and
        // they are picked up on the next IDLE edge.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      write_en_q   <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wr_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      write_en_q   <= write_en_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign write_en   = write_en_q;
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign wr_count   = wr_count_q;

`ifdef REGARB_FORWARD_EN
  // Bypass the register file while a write to the same index is in flight,
  // so the datapath never sees the stale value during the write cycle.
  always_comb begin
    fwd_data1 = rf_data1;
    fwd_data2 = rf_data2;
    if (write_en_q && (write_reg_q == rd_addr1)) begin
      fwd_data1 = write_data_q;
    end
    if (write_en_q && (write_reg_q == rd_addr2)) begin
      fwd_data2 = write_data_q;
    end
  end
`else
  assign fwd_data1 = rf_data1;
  assign fwd_data2 = rf_data2;

  // Read indices only feed the bypass compare.
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rd_addr1, rd_addr2};
`endif

endmodule
